// File: rtl/instruction_sequencer.sv
// Program sequencer feeding the datapath execution stage.
// Fetches instructions from a synchronous ROM, resolves control flow
// (halt, jump, branch-on-zero, counted loop) locally, and hands opcodes
// 1-3 to the datapath through a start/finished handshake. The datapath
// result is captured on completion so later branches can test it.
module instruction_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 4,
  parameter int RESULT_WIDTH      = 12,
  parameter int PROG_ADDR_WIDTH   = 8,
  parameter int LOOP_WIDTH        = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         run_i,
  output logic [PROG_ADDR_WIDTH-1:0]   prog_addr_o,
  input  logic [INSTRUCTION_WIDTH-1:0] prog_data_i,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_o,
  output logic                         start_o,
  input  logic                         finished_i,
  input  logic [RESULT_WIDTH-1:0]      result_i,
  output logic [RESULT_WIDTH-1:0]      last_result_o,
  output logic [LOOP_WIDTH-1:0]        loop_count_o,
  output logic                         busy_o,
  output logic                         halted_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HALT    = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PLOT    = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ    = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP    = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_BZ      = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOOP    = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SETLOOP = OPCODE_WIDTH'(7);

  state_t                         state_q;
  logic [PROG_ADDR_WIDTH-1:0]     pc_q;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q;
  logic [RESULT_WIDTH-1:0]        last_result_q;
  logic [LOOP_WIDTH-1:0]          loop_count_q;
  logic                           busy_q;
  logic                           halted_q;

  // Fields of the ROM word currently on prog_data_i (meaningful in DECODE).
  logic [OPCODE_WIDTH-1:0]        opcode_d;
  logic [PROG_ADDR_WIDTH-1:0]     target_d;
  logic [PROG_ADDR_WIDTH-1:0]     pc_inc_d;

  assign opcode_d = prog_data_i[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign target_d = prog_data_i[PROG_ADDR_WIDTH-1:0];
  // Sequential PC advance; wraps naturally at the top of the address space.
  assign pc_inc_d = pc_q + PROG_ADDR_WIDTH'(1);

  // The ROM address is the PC itself so the ROM samples it during FETCH.
  assign prog_addr_o   = pc_q;
  assign instruction_o = instr_q;
  assign last_result_o = last_result_q;
  assign loop_count_o  = loop_count_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  // Dispatch pulse exists only in ISSUE and only once the datapath is idle;
  // leaving ISSUE on the same edge guarantees it lasts exactly one cycle.
  assign start_o       = (state_q == ISSUE) && finished_i;

  // Sequencer FSM: fetch/decode loop, local control flow, datapath handshake.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      last_result_q <= '0;
      loop_count_q  <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_i) begin
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            state_q  <= FETCH;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          state_q <= FETCH;
          case (opcode_d)
            OP_HALT: begin
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= IDLE;
            end
            OP_PLOT, OP_READ, OP_WRITE: begin
              instr_q <= prog_data_i;
              state_q <= ISSUE;
            end
            OP_JUMP: pc_q <= target_d;
            OP_BZ:   pc_q <= (last_result_q == '0) ? target_d : pc_inc_d;
            OP_LOOP: begin
              if (loop_count_q != '0) begin
                loop_count_q <= loop_count_q - LOOP_WIDTH'(1);
                pc_q         <= target_d;
              end else begin
                pc_q <= pc_inc_d;
              end
            end
            OP_SETLOOP: begin
              loop_count_q <= prog_data_i[LOOP_WIDTH-1:0];
              pc_q         <= pc_inc_d;
            end
            default: pc_q <= pc_inc_d;
          endcase
        end
        ISSUE: begin
          if (finished_i) state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!finished_i) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (finished_i) begin
            last_result_q <= result_i;
            pc_q          <= pc_inc_d;
            state_q       <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Program-driven controller sitting directly upstream of the datapath execution stage. Fetches 32-bit instructions from a synchronous program ROM, executes control-flow opcodes (halt, jump, branch-on-zero, counted loop) locally, and dispatches plot/mem-read/mem-write opcodes (1–3) to the datapath over the start/finished handshake. Captures the datapath result on completion so it can be used for branching.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width; opcode is bits [31:28].
OPCODE_WIDTH, 4, opcode field width (MSBs of the instruction).
RESULT_WIDTH, 12, datapath result width.
PROG_ADDR_WIDTH, 8, program counter and ROM address width.
LOOP_WIDTH, 8, loop counter width.

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
run  in  1  start program at address 0 (sampled only in IDLE)
prog_addr  out  PROG_ADDR_WIDTH  ROM address, equal to the PC register
prog_data  in  INSTRUCTION_WIDTH  ROM data, valid one cycle after prog_addr
instruction  out  INSTRUCTION_WIDTH  instruction presented to datapath, registered
start  out  1  one-cycle dispatch pulse to datapath
finished  in  1  datapath idle/done flag (1 when idle)
result  in  RESULT_WIDTH  datapath result
last_result  out  RESULT_WIDTH  result latched at the end of each dispatched instruction
loop_count  out  LOOP_WIDTH  loop counter
busy  out  1  program running
halted  out  1  HALT executed; cleared by the next accepted run

Behaviour:
- Reset (resetn=0 at posedge): prog_addr/PC=0, instruction=0, start=0, last_result=0, loop_count=0, busy=0, halted=0, state=IDLE. Reset wins over every other event, including mid-dispatch. The datapath shares resetn.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: when run=1, set PC=0, busy=1, halted=0, then go to FETCH. run is ignored in every other state.
- FETCH (1 cycle): the ROM samples prog_addr=PC. Go to DECODE.
- DECODE (1 cycle): decode prog_data by opcode [31:28]:
  - 0 HALT: busy=0, halted=1, go to IDLE. PC is unchanged.
  - 1, 2, 3: instruction<=prog_data, go to ISSUE.
  - 4 JUMP: PC<=prog_data[PROG_ADDR_WIDTH-1:0], go to FETCH.
  - 5 BZ: if last_result==0, PC<=target [7:0]; else PC<=PC+1. Go to FETCH.
  - 6 LOOP: if loop_count!=0, loop_count-=1 and PC<=target [7:0]; else PC<=PC+1. Go to FETCH.
  - 7 SETLOOP: loop_count<=prog_data[LOOP_WIDTH-1:0], PC<=PC+1, go to FETCH.
  - 8–15: NOP, PC<=PC+1, go to FETCH.
- ISSUE: if finished=1, start=1 for exactly this cycle, then go to WAIT_ACK. If finished=0, hold start=0 and stay in ISSUE.
- WAIT_ACK: wait for finished=0. The datapath drops finished on the edge that samples start, so this normally lasts 1 cycle. Then go to WAIT_DONE.
- WAIT_DONE: on finished=1, latch last_result<=result (for all opcodes 1–3), PC<=PC+1, go to FETCH.
- instruction stays stable from DECODE until the next dispatch decode. The datapath reads it every cycle during execution.
- PC arithmetic is modulo 2^PROG_ADDR_WIDTH: 255+1 wraps to 0.
- Latency:
  - Control opcodes take 2 cycles (FETCH+DECODE).
  - Dispatched opcodes take FETCH+DECODE+ISSUE+WAIT_ACK plus the datapath's busy time.
- start is never asserted outside ISSUE and is never high for two consecutive cycles.

Test Plan:
1. ROM[0]=0x3005_0010, [1]=0x2000_0010, [2]=0x0000_0000; datapath model backed by a 64K×12 RAM; pulse run -> exactly 2 start pulses; instruction=0x3005_0010 then 0x2000_0010, each held through its WAIT_DONE; last_result=0x005; then busy=0, halted=1.
2. ROM[0]=0x7000_0003, [1]=0x1004_0105, [2]=0x6000_0001, [3]=HALT -> 4 start pulses with instruction 0x1004_0105; loop_count sequence 3,2,1,0; halts at PC=3.
3. BZ: ROM[0]=0x2000_0020 (mem[0x20]=0), [1]=0x5000_0005, [5]=HALT -> halts at PC=5. Repeat with mem[0x20]=7 and [2]=HALT -> halts at PC=2.
4. Reset mid-operation: assert resetn=0 during WAIT_DONE -> next cycle every output is 0 and state is IDLE. A subsequent run refetches from address 0. run pulses while busy=1 have no effect.
5. ROM[0]=0x4000_00FF, [255]=0xF000_0000 (NOP), [0] rewritten to HALT after the first pass -> PC wraps 255→0 and halts at 0. JUMP and NOP each take 2 cycles.
6. Datapath model holds finished=0 while ISSUE is reached -> start stays 0 until finished=1, then pulses once.
